bf_f_sequencer: RTL and testbench

//  Sequences one shared Blowfish S-box lookup port to compute F(x) = ((S1[a]+S2[b]) ^ S3[c]) + S4[d].

---
 rtl/bf_f_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_bf_f_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_f_sequencer.sv
// -----------------------------------------------------------------------------
// bf_f_sequencer
//   Computes the Blowfish F-function F(x) = ((S1[a]+S2[b]) ^ S3[c]) + S4[d]
//   for x = {a,b,c,d}. One shared S-box lookup port is used for all four
//   lookups, which are issued one after another while the result is
//   accumulated. The result is returned over a valid/ready handshake.
//
// Parameters
//   SBOX_REG  0: sbox_data is valid in the same cycle as sbox_sel/sbox_idx
//             1: sbox_data is valid one cycle later (registered ROM)
//   CNT_W     width of the completed-operation counter
//
// Ports
//   wb_clk_i   in   clock, rising edge
//   wb_rst_i   in   asynchronous, active-high reset
//   in_valid   in   x_in valid
//   in_ready   out  block can accept x_in (IDLE only)
//   x_in       in   F-function input {a,b,c,d}
//   out_valid  out  f_out valid (DONE only)
//   out_ready  in   consumer accepts f_out
//   f_out      out  F(x) result
//   sbox_sel   out  S-box select: 0=S1, 1=S2, 2=S3, 3=S4
//   sbox_idx   out  S-box index
//   sbox_data  in   S-box lookup result
//   busy       out  high in every state except IDLE
//   done_cnt   out  completed handshakes, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module bf_f_sequencer #(
    parameter int SBOX_REG = 0,
    parameter int CNT_W    = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      f_out,
    output logic [1:0]       sbox_sel,
    output logic [7:0]       sbox_idx,
    input  logic [31:0]      sbox_data,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LK_A = 3'd1;
    localparam logic [2:0] ST_LK_B = 3'd2;
    localparam logic [2:0] ST_LK_C = 3'd3;
    localparam logic [2:0] ST_LK_D = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    logic [2:0]       state_q,     state_d;
    logic             phase_q,     phase_d;
    logic [31:0]      x_reg_q,     x_reg_d;
    logic [31:0]      acc_q,       acc_d;
    logic [31:0]      f_out_q,     f_out_d;
    logic [1:0]       sbox_sel_q,  sbox_sel_d;
    logic [7:0]       sbox_idx_q,  sbox_idx_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;
    logic [CNT_W-1:0] done_cnt_q,  done_cnt_d;
    logic             capture_s;

    // With a registered ROM the data for an issued address arrives in the
    // second cycle of a lookup state; phase_q marks that capture cycle.
    assign capture_s = (SBOX_REG == 0) ? 1'b1 : phase_q;

    // Next-state logic. sbox_sel/sbox_idx are loaded on entry to each lookup
    // state so the registered outputs are valid for the whole state.
    always_comb begin
        state_d     = state_q;
        phase_d     = 1'b0;
        x_reg_d     = x_reg_q;
        acc_d       = acc_q;
        f_out_d     = f_out_q;
        sbox_sel_d  = sbox_sel_q;
        sbox_idx_d  = sbox_idx_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_cnt_d  = done_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_reg_d    = x_in;
                    sbox_sel_d = 2'd0;
                    sbox_idx_d = x_in[31:24];
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_LK_A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LK_A: begin
                if (capture_s) begin
                    acc_d      = sbox_data;
                    sbox_sel_d = 2'd1;
                    sbox_idx_d = x_reg_q[23:16];
                    state_d    = ST_LK_B;
                end else begin
                    phase_d = 1'b1;
                end
            end
            ST_LK_B: begin
                if (capture_s) begin
                    acc_d      = acc_q + sbox_data;
                    sbox_sel_d = 2'd2;
                    sbox_idx_d = x_reg_q[15:8];
                    state_d    = ST_LK_C;
                end else begin
                    phase_d = 1'b1;
                end
            end
            ST_LK_C: begin
                if (capture_s) begin
                    acc_d      = acc_q ^ sbox_data;
                    sbox_sel_d = 2'd3;
                    sbox_idx_d = x_reg_q[7:0];
                    state_d    = ST_LK_D;
                end else begin
                    phase_d = 1'b1;
                end
            end
            ST_LK_D: begin
                if (capture_s) begin
                    f_out_d     = acc_q + sbox_data;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    phase_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    done_cnt_d  = done_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            x_reg_q     <= 32'h0000_0000;
            acc_q       <= 32'h0000_0000;
            f_out_q     <= 32'h0000_0000;
            sbox_sel_q  <= 2'd0;
            sbox_idx_q  <= 8'h00;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            x_reg_q     <= x_reg_d;
            acc_q       <= acc_d;
            f_out_q     <= f_out_d;
            sbox_sel_q  <= sbox_sel_d;
            sbox_idx_q  <= sbox_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f_out     = f_out_q;
    assign sbox_sel  = sbox_sel_q;
    assign sbox_idx  = sbox_idx_q;
    assign busy      = busy_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_bf_f_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bf_f_sequencer
//   Two instances: u0 (SBOX_REG=0, CNT_W=16, combinational S-box stub) and
//   u1 (SBOX_REG=1, CNT_W=4, one-cycle-latency S-box stub). A cycle-count
//   reference model predicts every output each cycle; directed vectors pin
//   literal results, latency, lookup order, backpressure, reset and wrap.
// -----------------------------------------------------------------------------
module tb_bf_f_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid  [2];
    logic        out_ready [2];
    logic [31:0] x_in      [2];

    logic        in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
    logic [31:0] f_out0, f_out1;
    logic [1:0]  sbox_sel0, sbox_sel1;
    logic [7:0]  sbox_idx0, sbox_idx1;
    logic [31:0] sbox_data0;
    logic [31:0] sbox_data1 = 32'h0;
    logic [15:0] done_cnt0;
    logic [3:0]  done_cnt1;

    // observed outputs gathered per instance
    logic        ir_v [2], ov_v [2], bs_v [2];
    logic [31:0] fo_v [2];
    logic [1:0]  sel_v [2];
    logic [7:0]  idx_v [2];
    logic [15:0] dc_v [2];

    int checks = 0;
    int errors = 0;

    logic [31:0] s_const [4];
    bit use_hash = 1'b0;
    bit real_s2  = 1'b0;

    bf_f_sequencer #(.SBOX_REG(0), .CNT_W(16)) u0 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready0), .x_in(x_in[0]),
        .out_valid(out_valid0), .out_ready(out_ready[0]), .f_out(f_out0),
        .sbox_sel(sbox_sel0), .sbox_idx(sbox_idx0), .sbox_data(sbox_data0),
        .busy(busy0), .done_cnt(done_cnt0));

    bf_f_sequencer #(.SBOX_REG(1), .CNT_W(4)) u1 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready1), .x_in(x_in[1]),
        .out_valid(out_valid1), .out_ready(out_ready[1]), .f_out(f_out1),
        .sbox_sel(sbox_sel1), .sbox_idx(sbox_idx1), .sbox_data(sbox_data1),
        .busy(busy1), .done_cnt(done_cnt1));

    // S-box stub: constant per box, index hash, or the real S2[0] entry
    function automatic logic [31:0] sbox(input logic [1:0] s, input logic [7:0] idx);
        logic [31:0] t;
        if (real_s2 && s == 2'd1 && idx == 8'h00) return 32'h4b7a70e9;
        if (use_hash) begin
            t = {idx, ~idx, idx ^ 8'h3C, 6'h0, s};
            return t * 32'h9E3779B1 + {30'h0, s};
        end
        return s_const[s];
    endfunction

    function automatic logic [31:0] f_model(input logic [31:0] x);
        return ((sbox(2'd0, x[31:24]) + sbox(2'd1, x[23:16])) ^ sbox(2'd2, x[15:8]))
               + sbox(2'd3, x[7:0]);
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 5 : 9;
    endfunction

    function automatic int step(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] x, input int k);
        return 8'(x >> (8 * (3 - k)));
    endfunction

    always_comb sbox_data0 = sbox(sbox_sel0, sbox_idx0);
    always @(posedge clk) sbox_data1 <= sbox(sbox_sel1, sbox_idx1);

    always_comb begin
        ir_v[0] = in_ready0;  ir_v[1] = in_ready1;
        ov_v[0] = out_valid0; ov_v[1] = out_valid1;
        bs_v[0] = busy0;      bs_v[1] = busy1;
        fo_v[0] = f_out0;     fo_v[1] = f_out1;
        sel_v[0] = sbox_sel0; sel_v[1] = sbox_sel1;
        idx_v[0] = sbox_idx0; idx_v[1] = sbox_idx1;
        dc_v[0] = done_cnt0;  dc_v[1] = {12'h000, done_cnt1};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: cycles since accept ----------------
    bit          m_busy [2];
    int          m_t    [2];
    logic [31:0] m_x    [2], m_fn [2], m_f [2];
    logic [1:0]  m_sel  [2];
    logic [7:0]  m_idx  [2];
    int          m_cnt  [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] <= 1'b0; m_t[i] <= 0; m_x[i] <= 32'h0; m_fn[i] <= 32'h0;
                m_f[i] <= 32'h0; m_sel[i] <= 2'd0; m_idx[i] <= 8'h0; m_cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_busy[i]) begin
                    if (in_valid[i]) begin
                        m_busy[i] <= 1'b1;
                        m_t[i]    <= 1;
                        m_x[i]    <= x_in[i];
                        m_fn[i]   <= f_model(x_in[i]);
                        m_sel[i]  <= 2'd0;
                        m_idx[i]  <= x_in[i][31:24];
                    end
                end else if (m_t[i] < lat(i)) begin
                    m_t[i] <= m_t[i] + 1;
                    if (m_t[i] + 1 < lat(i)) begin
                        m_sel[i] <= 2'(m_t[i] / step(i));
                        m_idx[i] <= byte_of(m_x[i], m_t[i] / step(i));
                    end else begin
                        m_f[i] <= m_fn[i];
                    end
                end else if (out_ready[i]) begin
                    m_busy[i] <= 1'b0;
                    m_cnt[i]  <= m_cnt[i] + 1;
                end
            end
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                chk("in_ready", {31'h0, ir_v[i]}, {31'h0, !m_busy[i]});
                chk("busy", {31'h0, bs_v[i]}, {31'h0, m_busy[i]});
                chk("out_valid", {31'h0, ov_v[i]}, {31'h0, (m_busy[i] && m_t[i] >= lat(i))});
                chk("f_out", fo_v[i], m_f[i]);
                chk("sbox_sel", {30'h0, sel_v[i]}, {30'h0, m_sel[i]});
                chk("sbox_idx", {24'h0, idx_v[i]}, {24'h0, m_idx[i]});
                chk("done_cnt", {16'h0, dc_v[i]},
                    32'(m_cnt[i]) & ((i == 0) ? 32'h0000FFFF : 32'h0000000F));
            end
        end
    end

    task automatic chk_reset(input int i);
        chk("rst_in_ready", {31'h0, ir_v[i]}, 32'h1);
        chk("rst_out_valid", {31'h0, ov_v[i]}, 32'h0);
        chk("rst_busy", {31'h0, bs_v[i]}, 32'h0);
        chk("rst_f_out", fo_v[i], 32'h0);
        chk("rst_sel", {30'h0, sel_v[i]}, 32'h0);
        chk("rst_idx", {24'h0, idx_v[i]}, 32'h0);
        chk("rst_done_cnt", {16'h0, dc_v[i]}, 32'h0);
    endtask

    // One operation, entered and left at a negedge. Noise on in_valid, x_in
    // and out_ready while busy; hold = cycles of out_ready low in DONE.
    task automatic run_op(input int i, input logic [31:0] x, input int hold,
                          output logic [31:0] fo, output int n, output logic [39:0] tr);
        int k;
        logic [15:0] dc0;
        logic [31:0] mask;
        mask = (i == 0) ? 32'h0000FFFF : 32'h0000000F;
        tr = 40'h0;
        in_valid[i] = 1'b1;
        x_in[i] = x;
        k = 0;
        while (ir_v[i] !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("accept_timeout", {31'h0, (k < 200)}, 32'h1);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (ov_v[i] === 1'b1) break;
            if (n < lat(i)) tr[((n - 1) / step(i)) * 10 +: 10] = {sel_v[i], idx_v[i]};
            in_valid[i]  = 1'($urandom);
            x_in[i]      = $urandom;
            out_ready[i] = 1'($urandom);
        end
        chk("out_valid_timeout", {31'h0, ov_v[i]}, 32'h1);
        fo = fo_v[i];
        dc0 = dc_v[i];
        out_ready[i] = 1'b0;
        in_valid[i]  = 1'($urandom);
        repeat (hold) begin
            @(negedge clk);
            in_valid[i] = 1'($urandom);
            x_in[i]     = $urandom;
        end
        chk("hold_done_cnt", {16'h0, dc_v[i]}, {16'h0, dc0});
        chk("hold_f_out", fo_v[i], fo);
        out_ready[i] = 1'b1;
        @(negedge clk);
        out_ready[i] = 1'b0;
        in_valid[i]  = 1'b0;
        chk("release_done_cnt", {16'h0, dc_v[i]}, (32'(dc0) + 32'h1) & mask);
        chk("release_in_ready", {31'h0, ir_v[i]}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] fo;
        logic [39:0] tr;
        logic [39:0] tr_exp;
        int n;
        tr_exp = {2'd3, 8'hD4, 2'd2, 8'hC3, 2'd1, 8'hB2, 2'd0, 8'hA1};
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; x_in[i] = 32'h0;
        end
        s_const[0] = 32'h10; s_const[1] = 32'h20; s_const[2] = 32'hFF; s_const[3] = 32'h01;
        repeat (2) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        #2 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            s_const[0] = 32'h10; s_const[1] = 32'h20; s_const[2] = 32'hFF; s_const[3] = 32'h01;
            run_op(i, 32'h01234567, 0, fo, n, tr);
            chk("latency", 32'(n), (i == 0) ? 32'd5 : 32'd9);
            chk("stub_f", fo, 32'h000000D0);
            run_op(i, 32'hA1B2C3D4, 1, fo, n, tr);
            for (int k = 0; k < 4; k++) chk("trace", {22'h0, tr[k*10 +: 10]}, {22'h0, tr_exp[k*10 +: 10]});
            s_const[0] = 32'hFFFFFFFF; s_const[1] = 32'h2; s_const[2] = 32'h0; s_const[3] = 32'hFFFFFFFF;
            run_op(i, $urandom, 2, fo, n, tr);
            chk("wrap_f", fo, 32'h00000000);
            s_const[0] = 32'h0; s_const[1] = 32'h0; s_const[2] = 32'h0; s_const[3] = 32'h0;
            real_s2 = 1'b1;
            run_op(i, 32'h11000000, 0, fo, n, tr);
            chk("real_s2_f", fo, 32'h4b7a70e9);
            real_s2 = 1'b0;
            s_const[0] = 32'h10; s_const[1] = 32'h20; s_const[2] = 32'hFF; s_const[3] = 32'h01;
            run_op(i, 32'h01234567, 7, fo, n, tr);
            chk("backpressure_f", fo, 32'h000000D0);
        end

        // reset asserted during LK_C of u0
        in_valid[0] = 1'b1;
        x_in[0] = 32'h01234567;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midop_sel", {30'h0, sel_v[0]}, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_out_valid_after_rst", {31'h0, ov_v[0]}, 32'h0);
        run_op(0, 32'h01234567, 0, fo, n, tr);
        chk("after_rst_f", fo, 32'h000000D0);
        chk("after_rst_cnt", {16'h0, dc_v[0]}, 32'd1);

        // done_cnt wrap on the 4-bit instance
        for (int k = 0; k < 15; k++) run_op(1, $urandom, 0, fo, n, tr);
        chk("cnt_15", {16'h0, dc_v[1]}, 32'd15);
        run_op(1, $urandom, 0, fo, n, tr);
        chk("cnt_wrap_0", {16'h0, dc_v[1]}, 32'd0);

        // randomized operations with hashed S-boxes
        use_hash = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                run_op(i, $urandom, $urandom_range(0, 3), fo, n, tr);
                chk("rand_latency", 32'(n), (i == 0) ? 32'd5 : 32'd9);
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
